// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the memory bus arbiter: command encoding, address width,
// tag width and the owner of an outstanding memory tag.
package mem_bus_arbiter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } MEM_OWNER;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: tracks pending/owner/discard per memory tag and
// looks up the owner of the completion tag presented this cycle.
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_TAGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_tag,
    input  MEM_OWNER         alloc_owner,
    input  logic             alloc_discard,
    input  logic             flush,
    input  logic [TAG_W-1:0] cpl_tag,
    output logic             cpl_hit,
    output MEM_OWNER         cpl_owner,
    output logic             cpl_discard
);

    logic [NUM_TAGS-1:0] pending_q, pending_d;
    logic [NUM_TAGS-1:0] discard_q, discard_d;
    MEM_OWNER            owner_q [NUM_TAGS];
    MEM_OWNER            owner_d [NUM_TAGS];

    // Tag 0 means "no completion", so the lookup starts at 1.
    always_comb begin
        cpl_hit     = 1'b0;
        cpl_owner   = OWN_IF;
        cpl_discard = 1'b0;
        for (int t = 1; t < NUM_TAGS; t++) begin
            if (cpl_tag == TAG_W'(t) && pending_q[t]) begin
                cpl_hit     = 1'b1;
                cpl_owner   = owner_q[t];
                cpl_discard = discard_q[t];
            end
        end
    end

    // Allocation is applied last so it wins over a same-cycle completion.
    always_comb begin
        pending_d = pending_q;
        discard_d = discard_q;
        owner_d   = owner_q;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (flush && pending_q[t] && owner_q[t] == OWN_IF) begin
                discard_d[t] = 1'b1;
            end
            if (cpl_hit && cpl_tag == TAG_W'(t)) begin
                pending_d[t] = 1'b0;
            end
            if (alloc_valid && alloc_tag == TAG_W'(t)) begin
                pending_d[t] = 1'b1;
                owner_d[t]   = alloc_owner;
                discard_d[t] = alloc_discard;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            discard_q <= '0;
            for (int t = 0; t < NUM_TAGS; t++) begin
                owner_q[t] <= OWN_IF;
            end
        end else begin
            pending_q <= pending_d;
            discard_q <= discard_d;
            owner_q   <= owner_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (fetch vs. data) with starvation guard and
// tag-based routing of returned load data back to the requesting side.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned NUM_TAGS     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req,
    input  logic [XLEN-1:0]  if_addr,
    output logic             if_grant,
    input  logic             if_flush,
    output logic [63:0]      if_data,
    output logic             if_data_valid,
    input  logic             d_req,
    input  BUS_COMMAND       d_cmd,
    input  logic [XLEN-1:0]  d_addr,
    input  logic [63:0]      d_wdata,
    output logic             d_grant,
    output logic [63:0]      d_rdata,
    output logic             d_rdata_valid,
    output BUS_COMMAND       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [TAG_W-1:0] mem2proc_tag,
    input  logic [63:0]      mem2proc_data
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             sel_if, sel_d, accepted;
    logic             alloc_valid, alloc_discard;
    MEM_OWNER         alloc_owner;
    logic             cpl_hit, cpl_discard;
    MEM_OWNER         cpl_owner;
    logic             deliver_if, deliver_d;

    // Data side normally wins; fetch wins once data has starved it long enough.
    always_comb begin
        sel_if   = if_req && (!d_req || starve_q == CNT_MAX);
        sel_d    = d_req && !sel_if;
        accepted = reset && (mem2proc_response != '0);
        if_grant = sel_if && accepted;
        d_grant  = sel_d && accepted;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (reset) begin
            if (sel_if) begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = if_addr;
            end else if (sel_d) begin
                proc2mem_command = d_cmd;
                proc2mem_addr    = d_addr;
                proc2mem_data    = d_wdata;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_grant) begin
            starve_d = '0;
        end else if (d_grant && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        alloc_valid   = if_grant || (d_grant && d_cmd == BUS_LOAD);
        alloc_owner   = if_grant ? OWN_IF : OWN_D;
        alloc_discard = if_grant && if_flush;
        deliver_if    = cpl_hit && !cpl_discard && cpl_owner == OWN_IF;
        deliver_d     = cpl_hit && !cpl_discard && cpl_owner == OWN_D;
    end

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_table (
        .clock         (clock),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_tag     (mem2proc_response),
        .alloc_owner   (alloc_owner),
        .alloc_discard (alloc_discard),
        .flush         (if_flush),
        .cpl_tag       (mem2proc_tag),
        .cpl_hit       (cpl_hit),
        .cpl_owner     (cpl_owner),
        .cpl_discard   (cpl_discard)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q      <= '0;
            if_data_valid <= 1'b0;
            d_rdata_valid <= 1'b0;
            if_data       <= '0;
            d_rdata       <= '0;
        end else begin
            starve_q      <= starve_d;
            if_data_valid <= deliver_if;
            d_rdata_valid <= deliver_d;
            if (deliver_if) begin
                if_data <= mem2proc_data;
            end
            if (deliver_d) begin
                d_rdata <= mem2proc_data;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants while a fetch waits.
REQ-002 SHALL have parameter NUM_TAGS, default 16, meaning the memory tag space; tag 0 means "none".
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port if_req, input, 1 bit: fetch side requests a LOAD this cycle.
REQ-006 SHALL have port if_addr, input, XLEN bits: fetch address, already 8-byte aligned.
REQ-007 SHALL have port if_grant, output, 1 bit: fetch command issued and accepted this cycle; drives the fetch unit's mem_bus_none.
REQ-008 SHALL have port if_flush, input, 1 bit: a taken branch; all in-flight fetch data becomes stale.
REQ-009 SHALL have port if_data / if_data_valid, output, 64 / 1 bits: returned fetch line.
REQ-010 SHALL have port d_req, input, 1 bit: data side request.
REQ-011 SHALL have port d_cmd, input, BUS_COMMAND: BUS_LOAD or BUS_STORE.
REQ-012 SHALL have port d_addr / d_wdata, input, XLEN / 64 bits: data address and store data.
REQ-013 SHALL have port d_grant, output, 1 bit: data command issued and accepted this cycle.
REQ-014 SHALL have port d_rdata / d_rdata_valid, output, 64 / 1 bits: returned load data.
REQ-015 SHALL have port proc2mem_command / proc2mem_addr / proc2mem_data, output, BUS_COMMAND / XLEN / 64 bits: memory request.
REQ-016 SHALL have port mem2proc_response / mem2proc_tag, input, 4 / 4 bits: accept tag (0 = rejected) and completion tag (0 = none).
REQ-017 SHALL have port mem2proc_data, input, 64 bits: data for mem2proc_tag.

Function
REQ-018 SHALL select the requester combinationally each cycle: data wins, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
REQ-019 SHALL drive proc2mem_* from the selected requester, and SHALL drive BUS_NONE with addr/data 0 when neither requests.
REQ-020 SHALL assert if_grant/d_grant only when that side is selected and mem2proc_response!=0; a rejected request is retried by the requester holding its req.
REQ-021 SHALL, on an accepted LOAD with tag T, set pending[T]=1, owner[T]=requester, and discard[T]=if_flush for a fetch accept (0 for data); STOREs allocate nothing.
REQ-022 SHALL, when mem2proc_tag=T!=0 and pending[T]=1, clear pending[T] and register the data for one cycle onto the owner's data port with valid=1, unless discard[T]=1, in which case the data is dropped.
REQ-023 SHALL ignore completions for tags that are not pending.
REQ-024 SHALL, on if_flush=1, set discard for every pending fetch-owned tag.
REQ-025 SHALL let an allocation of tag T win over a same-cycle completion of T, so that pending[T] stays 1 with the new owner.
REQ-026 SHALL keep starve_cnt (saturating): it increments when d_grant=1 with if_req=1; it clears on if_grant or when if_req=0.
REQ-027 SHALL have a read-data latency of exactly 1 cycle from the completion tag to *_valid.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear pending, owner, discard, starve_cnt, if_data_valid, d_rdata_valid, if_data and d_rdata.
REQ-029 SHALL hold proc2mem_command at BUS_NONE and both grants at 0 while reset=0.
REQ-030 SHALL drop any completion that arrives during reset.

Structure
REQ-031 SHALL take BUS_COMMAND and XLEN from sys_defs.svh, and SHALL add a shared typedef MEM_OWNER (OWN_IF/OWN_D) there.
REQ-032 SHALL be a single module; the tag table (pending/owner/discard) is a natural sub-module named mem_tag_table.

Verification
REQ-033 SHALL cover: if_req only, addr 0x40, response 3, tag 3 two cycles later with data 0xDEAD -> if_grant=1 in the issue cycle, if_data=0xDEAD with valid 1 cycle after the tag.
REQ-034 SHALL cover: if_req and d_req held high with response always 1..15 -> exactly 4 d_grants, then 1 if_grant, repeating.
REQ-035 SHALL cover: fetch accepted with tag 5, if_flush the next cycle, tag 5 returns -> if_data_valid stays 0.
REQ-036 SHALL cover: response=0 for 3 cycles with d_req held -> no d_grant and no allocation; on the 4th cycle response 2 -> d_grant=1.
REQ-037 SHALL cover: tag 7 completes for data while tag 7 is re-allocated to fetch in the same cycle -> d_rdata_valid next cycle, and the later tag-7 return is routed to fetch.
REQ-038 SHALL cover: reset asserted mid-flight with 3 tags pending -> all valids 0 and BUS_NONE immediately, and subsequent returns are ignored.
